// File: rtl/niossoc_ram_pkg.sv
// Shared definitions for the on-chip RAM arbiter: port identifiers and
// the legal range of the read latency parameter.
package niossoc_ram_pkg;

    typedef enum logic {
        PORT_S1 = 1'b0,
        PORT_S2 = 1'b1
    } port_t;

    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 2;

    function automatic bit read_latency_legal(input int unsigned lat);
        return (lat == READ_LATENCY_MIN) || (lat == READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/niossoc_ram_core.sv
// Single-port, byte-enabled, synchronous-read RAM. Contents are never
// touched by reset.
module niossoc_ram_core #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W/8-1:0]   byteenable,
  input  logic [DATA_W-1:0]     writedata,
  output logic [DATA_W-1:0]     readdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Byte-lane write and registered read; en freezes both the array and the output.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned b = 0; b < DATA_W/8; b++) begin
          if (byteenable[b]) begin
            mem[address][b*8 +: 8] <= writedata[b*8 +: 8];
          end
        end
      end
      readdata <= mem[address];
    end
  end

endmodule

// File: rtl/niossoc_onchip_ram_arb.sv
// Two-port Avalon-MM front end for a shared on-chip RAM: round-robin
// arbitration, a tagged read pipeline and per-port read-data hold registers.
module niossoc_onchip_ram_arb
    import niossoc_ram_pkg::*;
#(
    parameter int    DATA_W       = 32,
    parameter int    ADDR_W       = 10,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = "niossoc_onchip_ram_arb.hex"
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic [ADDR_W-1:0]     s1_address,
    input  logic [DATA_W/8-1:0]   s1_byteenable,
    input  logic                  s1_chipselect,
    input  logic                  s1_read,
    input  logic                  s1_write,
    input  logic [DATA_W-1:0]     s1_writedata,
    output logic                  s1_waitrequest,
    output logic [DATA_W-1:0]     s1_readdata,
    output logic                  s1_readdatavalid,
    input  logic [ADDR_W-1:0]     s2_address,
    input  logic [DATA_W/8-1:0]   s2_byteenable,
    input  logic                  s2_chipselect,
    input  logic                  s2_read,
    input  logic                  s2_write,
    input  logic [DATA_W-1:0]     s2_writedata,
    output logic                  s2_waitrequest,
    output logic [DATA_W-1:0]     s2_readdata,
    output logic                  s2_readdatavalid
);

    localparam int LAST = READ_LATENCY - 1;

    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("niossoc_onchip_ram_arb: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_width
        $error("niossoc_onchip_ram_arb: DATA_W must be a multiple of 8");
    end

    logic                req1, req2;
    logic                grant1, grant2;
    port_t               last_grant;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W/8-1:0] mem_be;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_we;
    logic                rd_issue;
    port_t               rd_port;
    logic [DATA_W-1:0]   core_q;
    logic [DATA_W-1:0]   out_data;
    logic [LAST:0]       pipe_vld;
    port_t               pipe_tag [READ_LATENCY];
    logic [DATA_W-1:0]   hold1, hold2;

    assign req1 = s1_chipselect & (s1_read | s1_write);
    assign req2 = s2_chipselect & (s2_read | s2_write);

    // Grant at most one requester per enabled cycle; on contention favour the port not granted last.
    always_comb begin
        grant1 = 1'b0;
        grant2 = 1'b0;
        if (clken) begin
            if (req1 && req2) begin
                grant1 = (last_grant == PORT_S2);
                grant2 = (last_grant == PORT_S1);
            end else begin
                grant1 = req1;
                grant2 = req2;
            end
        end
    end

    assign s1_waitrequest = req1 & ~grant1;
    assign s2_waitrequest = req2 & ~grant2;

    // Round-robin pointer, advanced on every grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= PORT_S2;
        end else if (grant1 || grant2) begin
            last_grant <= grant1 ? PORT_S1 : PORT_S2;
        end
    end

    // Steer the granted port onto the RAM; read+write together is a write.
    always_comb begin
        mem_addr  = s1_address;
        mem_be    = s1_byteenable;
        mem_wdata = s1_writedata;
        mem_we    = 1'b0;
        rd_issue  = 1'b0;
        rd_port   = PORT_S1;
        if (grant1) begin
            mem_we   = s1_write;
            rd_issue = s1_read & ~s1_write;
        end else if (grant2) begin
            mem_addr  = s2_address;
            mem_be    = s2_byteenable;
            mem_wdata = s2_writedata;
            mem_we    = s2_write;
            rd_issue  = s2_read & ~s2_write;
            rd_port   = PORT_S2;
        end
    end

    niossoc_ram_core #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_core (
        .clk        (clk),
        .en         (clken),
        .we         (mem_we),
        .address    (mem_addr),
        .byteenable (mem_be),
        .writedata  (mem_wdata),
        .readdata   (core_q)
    );

    // Valid/tag shift register tracking each read to its issuing port; frozen while clken is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe_tag[i] <= PORT_S1;
            end
        end else if (clken) begin
            pipe_vld[0] <= rd_issue;
            pipe_tag[0] <= rd_port;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    // The RAM output register is the first data stage; a second stage is added for latency 2.
    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_W-1:0] q_d;
        // Extra data stage aligned with pipe_vld[1].
        always_ff @(posedge clk) begin
            if (clken) begin
                q_d <= core_q;
            end
        end
        assign out_data = q_d;
    end else begin : g_lat1
        assign out_data = core_q;
    end

    assign s1_readdatavalid = clken & pipe_vld[LAST] & (pipe_tag[LAST] == PORT_S1);
    assign s2_readdatavalid = clken & pipe_vld[LAST] & (pipe_tag[LAST] == PORT_S2);

    // Per-port copy of the last delivered word so readdata holds between valid pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold1 <= '0;
            hold2 <= '0;
        end else begin
            if (s1_readdatavalid) hold1 <= out_data;
            if (s2_readdatavalid) hold2 <= out_data;
        end
    end

    assign s1_readdata = s1_readdatavalid ? out_data : hold1;
    assign s2_readdata = s2_readdatavalid ? out_data : hold2;

endmodule

// File: tb/tb_niossoc_onchip_ram_arb.sv
// Bench for niossoc_onchip_ram_arb: two instances (READ_LATENCY 1 and 2)
// share stimulus and are compared against a cycle-level behavioural model.
module tb_niossoc_onchip_ram_arb;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int BW = DW/8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic clken;
    logic [AW-1:0] s1_address, s2_address;
    logic [BW-1:0] s1_byteenable, s2_byteenable;
    logic s1_chipselect, s1_read, s1_write;
    logic s2_chipselect, s2_read, s2_write;
    logic [DW-1:0] s1_writedata, s2_writedata;

    logic          wait1 [2];
    logic          wait2 [2];
    logic          rdv1  [2];
    logic          rdv2  [2];
    logic [DW-1:0] rdat1 [2];
    logic [DW-1:0] rdat2 [2];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 2; d++) begin : g_dut
        niossoc_onchip_ram_arb #(
            .DATA_W       (DW),
            .ADDR_W       (AW),
            .READ_LATENCY (d + 1),
            .INIT_FILE    ("")
        ) dut (
            .clk              (clk),
            .reset            (reset),
            .clken            (clken),
            .s1_address       (s1_address),
            .s1_byteenable    (s1_byteenable),
            .s1_chipselect    (s1_chipselect),
            .s1_read          (s1_read),
            .s1_write         (s1_write),
            .s1_writedata     (s1_writedata),
            .s1_waitrequest   (wait1[d]),
            .s1_readdata      (rdat1[d]),
            .s1_readdatavalid (rdv1[d]),
            .s2_address       (s2_address),
            .s2_byteenable    (s2_byteenable),
            .s2_chipselect    (s2_chipselect),
            .s2_read          (s2_read),
            .s2_write         (s2_write),
            .s2_writedata     (s2_writedata),
            .s2_waitrequest   (wait2[d]),
            .s2_readdata      (rdat2[d]),
            .s2_readdatavalid (rdv2[d])
        );
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory image of the exercised window, arbiter pointer,
    // count of enabled cycles, and outstanding reads stamped with their grant cycle.
    typedef struct {
        int          port;
        logic [DW-1:0] data;
        int          g;
    } rsp_t;

    logic [DW-1:0] mem_m [32];
    int            last_g = 1;
    int            active = 0;
    rsp_t          pend[$];
    logic [DW-1:0] last_rd [2][2];
    int            vcount [2];

    task automatic idle();
        s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
        s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    endtask

    task automatic drive(input int p, input bit rd, input bit wr, input int addr,
                         input logic [BW-1:0] be, input logic [DW-1:0] data);
        if (p == 0) begin
            s1_chipselect = rd | wr; s1_read = rd; s1_write = wr;
            s1_address = AW'(addr); s1_byteenable = be; s1_writedata = data;
        end else begin
            s2_chipselect = rd | wr; s2_read = rd; s2_write = wr;
            s2_address = AW'(addr); s2_byteenable = be; s2_writedata = data;
        end
    endtask

    task automatic step();
        bit q1, q2, ev, wr, rd;
        int g, a;
        logic [DW-1:0] ed, w, got_d;
        logic [BW-1:0] be;
        logic got_v;
        @(negedge clk);
        q1 = s1_chipselect && (s1_read || s1_write);
        q2 = s2_chipselect && (s2_read || s2_write);
        g = -1;
        if (clken) begin
            if (q1 && q2) g = (last_g == 1) ? 0 : 1;
            else if (q1) g = 0;
            else if (q2) g = 1;
        end
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("lat%0d_s1_waitrequest", d+1), 64'(wait1[d]), 64'(q1 && g != 0));
            check_eq($sformatf("lat%0d_s2_waitrequest", d+1), 64'(wait2[d]), 64'(q2 && g != 1));
            for (int p = 0; p < 2; p++) begin
                ev = 1'b0;
                ed = last_rd[d][p];
                if (clken) begin
                    foreach (pend[i]) begin
                        if (pend[i].port == p && pend[i].g + d + 1 == active) begin
                            ev = 1'b1;
                            ed = pend[i].data;
                        end
                    end
                end
                got_v = (p == 0) ? rdv1[d] : rdv2[d];
                got_d = (p == 0) ? rdat1[d] : rdat2[d];
                check_eq($sformatf("lat%0d_s%0d_readdatavalid", d+1, p+1), 64'(got_v), 64'(ev));
                check_eq($sformatf("lat%0d_s%0d_readdata", d+1, p+1), 64'(got_d), 64'(ed));
                last_rd[d][p] = ed;
                if (d == 0 && got_v === 1'b1) vcount[p]++;
            end
        end
        if (g >= 0) begin
            last_g = g;
            a  = (g == 0) ? int'(s1_address[4:0]) : int'(s2_address[4:0]);
            wr = (g == 0) ? s1_write : s2_write;
            rd = (g == 0) ? s1_read : s2_read;
            be = (g == 0) ? s1_byteenable : s2_byteenable;
            w  = (g == 0) ? s1_writedata : s2_writedata;
            if (wr) begin
                for (int b = 0; b < BW; b++) begin
                    if (be[b]) mem_m[a][b*8 +: 8] = w[b*8 +: 8];
                end
            end else if (rd) begin
                pend.push_back('{g, mem_m[a], active});
            end
        end
        if (clken) active++;
        while (pend.size() > 0 && pend[0].g + 2 < active) void'(pend.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("rst_lat%0d_s1_readdatavalid", d+1), 64'(rdv1[d]), 64'(0));
            check_eq($sformatf("rst_lat%0d_s2_readdatavalid", d+1), 64'(rdv2[d]), 64'(0));
            check_eq($sformatf("rst_lat%0d_s1_readdata", d+1), 64'(rdat1[d]), 64'(0));
            check_eq($sformatf("rst_lat%0d_s2_readdata", d+1), 64'(rdat2[d]), 64'(0));
        end
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        pend.delete();
        last_g = 1;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) last_rd[d][p] = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clken = 1'b1;
        s1_address = '0; s2_address = '0;
        s1_byteenable = '0; s2_byteenable = '0;
        s1_writedata = '0; s2_writedata = '0;
        idle();
        do_reset();

        // Give every word in the exercised window a known value.
        for (int a = 0; a < 32; a++) begin
            idle(); drive(0, 0, 1, a, '1, $urandom); step();
        end

        // Write then read back through s1; s2 must stay quiet.
        idle(); drive(0, 0, 1, 5, 4'hF, 32'hDEADBEEF); step();
        idle(); drive(0, 1, 0, 5, '0, '0); step();
        idle(); step(); step();

        // Partial byte-lane write on s2 over a known word.
        idle(); drive(0, 0, 1, 16, 4'hF, 32'h11223344); step();
        idle(); drive(1, 0, 1, 16, 4'h5, 32'hAABBCCDD); step();
        idle(); drive(1, 1, 0, 16, '0, '0); step();
        idle(); step(); step();

        // Contention straight after reset: grants alternate, two responses per port.
        do_reset();
        vcount[0] = 0; vcount[1] = 0;
        idle(); drive(0, 1, 0, 1, '0, '0); drive(1, 1, 0, 2, '0, '0);
        for (int i = 0; i < 4; i++) step();
        idle(); step(); step(); step();
        check_eq("contention_s1_valid_count", 64'(vcount[0]), 64'(2));
        check_eq("contention_s2_valid_count", 64'(vcount[1]), 64'(2));

        // Back-to-back reads at 0,1,2.
        for (int a = 0; a < 3; a++) begin
            idle(); drive(0, 1, 0, a, '0, '0); step();
        end
        idle(); step(); step(); step();

        // Clock-enable stall across a read in flight.
        idle(); drive(0, 1, 0, 5, '0, '0); step();
        idle(); clken = 1'b0; step(); step(); step();
        clken = 1'b1; step(); step(); step();

        // Reset asserted while a read is in flight.
        idle(); drive(0, 1, 0, 7, '0, '0); step();
        do_reset();
        idle(); step(); step(); step();

        // Randomized traffic over the exercised window.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            clken = ($urandom_range(0, 9) != 0);
            s1_chipselect = ($urandom_range(0, 3) != 0);
            s1_read       = 1'($urandom);
            s1_write      = 1'($urandom_range(0, 2) == 0);
            s1_address    = AW'($urandom_range(0, 31));
            s1_byteenable = BW'($urandom);
            s1_writedata  = $urandom;
            s2_chipselect = ($urandom_range(0, 3) != 0);
            s2_read       = 1'($urandom);
            s2_write      = 1'($urandom_range(0, 2) == 0);
            s2_address    = AW'($urandom_range(0, 31));
            s2_byteenable = BW'($urandom);
            s2_writedata  = $urandom;
            step();
        end
        clken = 1'b1;
        idle(); step(); step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/niossoc_onchip_ram_arb.md
NIOSSOC_ONCHIP_RAM_ARB -- requirements
Module: niossoc_onchip_ram_arb

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10, word-address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter READ_LATENCY, default 1, grant-to-readdatavalid delay in cycles; legal values 1 or 2.
REQ-004 Parameter INIT_FILE, default "niossoc_onchip_ram_arb.hex", memory initialisation image.
REQ-005 clk  in  1  single clock; all state SHALL be on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 clken  in  1  global clock enable; 0 SHALL freeze all state.
REQ-008 sN_address  in  ADDR_W  word address, port N in {1,2}.
REQ-009 sN_byteenable  in  DATA_W/8  byte-lane enables for writes.
REQ-010 sN_chipselect, sN_read, sN_write  in  1 each  Avalon-MM request qualifiers.
REQ-011 sN_writedata  in  DATA_W  write data.
REQ-012 sN_waitrequest  out  1  request not accepted this cycle.
REQ-013 sN_readdata  out  DATA_W  read data.
REQ-014 sN_readdatavalid  out  1  sN_readdata valid this cycle.

Function
REQ-015 Port N SHALL request when sN_chipselect & (sN_read | sN_write).
REQ-016 At most one access SHALL be granted per cycle, and only when clken=1.
REQ-017 Single requester: it SHALL be granted in the same cycle.
REQ-018 Both requesting: grant SHALL go to the port not granted most recently (round-robin, 1-bit last_grant pointer updated on every grant).
REQ-019 sN_waitrequest SHALL equal request_N & ~grant_N, combinationally; 0 when idle.
REQ-020 Granted write: bytes with byteenable=1 SHALL update at the grant edge; other bytes SHALL be unchanged.
REQ-021 sN_read and sN_write both asserted: SHALL be treated as a write; no readdatavalid.
REQ-022 Granted read: sN_readdatavalid SHALL pulse for exactly 1 cycle, READ_LATENCY cycles after the grant cycle, with the addressed word on sN_readdata.
REQ-023 Read granted the cycle after a write to the same address SHALL return the new data; ordering is the grant order.
REQ-024 sN_readdata SHALL hold its last value when sN_readdatavalid=0.
REQ-025 Reads SHALL be fully pipelined: one granted read per cycle yields one readdatavalid per cycle, in order, routed to the issuing port by a per-stage port tag.
REQ-026 clken=0 SHALL stall the read pipeline and arbiter pointer. Requests SHALL see waitrequest=1. readdatavalid SHALL be 0 and resume on the stalled stage when clken returns.
REQ-027 Address wrap SHALL NOT apply: addresses are full-width and every value is in range.

Reset
REQ-028 On reset, sN_readdatavalid=0, sN_readdata=0, pipeline valids cleared, last_grant=s2 (s1 wins first contention).
REQ-029 A read in flight at reset assertion SHALL be dropped with no readdatavalid afterwards.
REQ-030 Memory contents SHALL NOT be affected by reset; they SHALL hold INIT_FILE contents after configuration.
REQ-031 Outputs SHALL reach reset values asynchronously; release SHALL be synchronous to clk.

Structure
REQ-032 Shared package niossoc_ram_pkg SHALL hold the port-id enum (PORT_S1, PORT_S2) and the READ_LATENCY legal-value constants.
REQ-033 Storage SHALL be a sub-module niossoc_ram_core: single-port, byte-enabled, synchronous-read RAM of DATA_W x 2**ADDR_W loaded from INIT_FILE.
REQ-034 Arbitration, tag pipeline and output registers SHALL live in the top module.
REQ-035 An illegal READ_LATENCY SHALL fail elaboration.

Verification
REQ-036 s1 write 0xDEADBEEF @0x005, be=0xF, then s1 read @0x005 -> readdatavalid 1 cycle later (LAT=1), readdata=0xDEADBEEF, s2 outputs quiet.
REQ-037 Word @0x010=0x11223344. s2 write 0xAABBCCDD be=0x5, then read @0x010 -> 0x11BB33DD.
REQ-038 Both ports read simultaneously for 4 cycles after reset -> grants alternate s1,s2,s1,s2; waitrequest toggles on the loser; each port gets 2 readdatavalid pulses in order.
REQ-039 LAT=2: s1 reads @0,1,2 back-to-back -> readdatavalid cycles 2,3,4 after the first grant with matching data.
REQ-040 s1 read granted, clken dropped 3 cycles then restored -> no valid while clken=0, exactly one valid afterwards with correct data; reset pulse during a read -> no valid at all.
